// File: rtl/alu_bcd_converter.sv
// Iterative double-dabble converter: ALU result (optionally signed) to BCD magnitude
// digits plus a sign glyph, one result bit per clock.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// CONV  | shift-and-add-3 in progress, one bit per clock

module alu_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [3:0]            sign_digit,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]   scr_q, scr_d, scr_adj, scr_shift;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            done_q, done_d;
  logic            neg_q, neg_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0] value_abs;

  // Two's-complement negate wraps correctly for the most negative input.
  assign value_abs = (is_signed && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    scr_shift = {scr_adj[BW-2:0], mag_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d   = value_abs;
          sign_d  = is_signed & value[WIDTH-1];
          scr_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        scr_d = scr_shift;
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = scr_shift;
          neg_d   = sign_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy       = (state_q == CONV);
  assign done       = done_q;
  assign neg        = neg_q;
  assign sign_digit = neg_q ? 4'd15 : 4'd0;
  assign bcd        = bcd_q;

endmodule

// File: tb/tb_alu_bcd_converter.sv
// Bench for alu_bcd_converter: expected results are queued at start and
// compared when done pulses.

module tb_alu_bcd_converter;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [7:0]  value;
  logic        busy, done, neg;
  logic [3:0]  sign_digit;
  logic [11:0] bcd;

  typedef struct {
    logic [11:0] bcd;
    logic        neg;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .is_signed(is_signed),
    .busy(busy), .done(done), .neg(neg), .sign_digit(sign_digit), .bcd(bcd)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] v, input logic s);
    exp_t e;
    int   m;
    m = (s && v[7]) ? 256 - int'(v) : int'(v);
    e.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    e.neg = s && v[7];
    return e;
  endfunction

  // Drive start for one accepting edge; returns at the negedge after it.
  task automatic do_start(input logic [7:0] v, input logic s, input bit push);
    @(negedge clk);
    start = 1'b1; value = v; is_signed = s;
    if (push) sb.push_back(model(v, s));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; reports cycles and busy-high samples seen. No checking here.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles = 0; busy_cnt = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; value = '0; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({busy, done, neg, sign_digit, bcd} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b neg=%b sign=%0d bcd=%h, want all 0",
               busy, done, neg, sign_digit, bcd);
    end
  endtask

  task automatic test_convert(input logic [7:0] v, input logic s, input bit chk_busy);
    int   cyc, bcnt;
    exp_t e;
    do_start(v, s, 1'b1);
    wait_done(cyc, bcnt);
    e = (sb.size() > 0) ? sb.pop_front() : '{bcd: 12'hxxx, neg: 1'bx};
    tests++;
    if (cyc !== 8) begin
      fails++; $display("FAIL latency v=%h s=%b: got %0d cycles, want 8", v, s, cyc);
    end
    tests++;
    if (bcd !== e.bcd || neg !== e.neg || sign_digit !== (e.neg ? 4'd15 : 4'd0)) begin
      fails++;
      $display("FAIL result v=%h s=%b: got bcd=%h neg=%b sign=%0d, want bcd=%h neg=%b",
               v, s, bcd, neg, sign_digit, e.bcd, e.neg);
    end
    if (chk_busy) begin
      tests++;
      if (bcnt !== 8 || busy !== 1'b0) begin
        fails++; $display("FAIL busy_window: got %0d busy cycles busy_at_done=%b, want 8 and 0", bcnt, busy);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || bcd !== e.bcd) begin
      fails++; $display("FAIL done_pulse v=%h: got done=%b bcd=%h after pulse, want 0 and %h", v, done, bcd, e.bcd);
    end
  endtask

  task automatic test_start_while_busy;
    int   ndone;
    exp_t e;
    logic [11:0] bcd_seen;
    do_start(8'h64, 1'b0, 1'b1);
    ndone = 0; bcd_seen = 'x;
    for (int i = 1; i <= 20; i++) begin
      start = (i == 2 || i == 5); value = 8'h09; is_signed = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin ndone++; bcd_seen = bcd; end
    end
    start = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '{bcd: 12'hxxx, neg: 1'bx};
    tests++;
    if (ndone !== 1 || bcd_seen !== e.bcd || bcd !== e.bcd) begin
      fails++;
      $display("FAIL start_while_busy: got %0d dones bcd=%h final=%h, want 1 done bcd=%h", ndone, bcd_seen, bcd, e.bcd);
    end
  endtask

  task automatic test_back_to_back;
    int   cyc, bcnt, gap;
    bit   held;
    exp_t e;
    @(negedge clk);
    start = 1'b1; value = 8'h2A; is_signed = 1'b0;
    sb.push_back(model(8'h2A, 1'b0));
    @(negedge clk);
    wait_done(cyc, bcnt);
    e = (sb.size() > 0) ? sb.pop_front() : '{bcd: 12'hxxx, neg: 1'bx};
    tests++;
    if (bcd !== e.bcd || cyc !== 8) begin
      fails++; $display("FAIL b2b_first: got bcd=%h after %0d cycles, want %h after 8", bcd, cyc, e.bcd);
    end
    value = 8'h63;
    sb.push_back(model(8'h63, 1'b0));
    @(negedge clk);
    start = 1'b0;
    gap = 1; held = 1'b1;
    while (done !== 1'b1 && gap < 40) begin
      if (bcd !== 12'h042) held = 1'b0;
      @(negedge clk);
      gap++;
    end
    tests++;
    if (!held) begin
      fails++; $display("FAIL b2b_hold: got bcd change before second done, want 042 held");
    end
    e = (sb.size() > 0) ? sb.pop_front() : '{bcd: 12'hxxx, neg: 1'bx};
    tests++;
    if (gap !== 9 || bcd !== e.bcd) begin
      fails++; $display("FAIL b2b_second: got bcd=%h gap=%0d, want %h gap 9", bcd, gap, e.bcd);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    test_convert(8'hFF, 1'b0, 1'b0);
    do_start(8'h01, 1'b0, 1'b0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || neg !== 1'b0) begin
      fails++; $display("FAIL reset_mid_state: got busy=%b done=%b bcd=%h neg=%b, want 0", busy, done, bcd, neg);
    end
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++; $display("FAIL reset_mid_done: got done pulse after abandoned conversion, want none");
    end
    test_convert(8'h05, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_convert(8'h00, 1'b0, 1'b1);
    test_convert(8'hFF, 1'b0, 1'b0);
    test_convert(8'hFF, 1'b1, 1'b0);
    test_convert(8'h80, 1'b1, 1'b0);
    test_convert(8'h7F, 1'b1, 1'b0);
    test_convert(8'h0A, 1'b0, 1'b0);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 6; i++) test_convert(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
